// File: rtl/bullet_fire_scheduler.sv
// Shot scheduler for the bullet slot pool: synchronises the shoot button, grants free slots
// round-robin as one-cycle fire pulses, and runs the cooldown, magazine and reload timers.
module bullet_fire_scheduler #(
    parameter int N_SLOTS      = 5,
    parameter int MAG_SIZE     = 5,
    parameter int MAG_W        = 5,
    parameter int COOLDOWN_CYC = 200000,
    parameter int RELOAD_CYC   = 2000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shoot,
    input  logic               reload_req,
    input  logic [N_SLOTS-1:0] slot_busy,
    output logic [N_SLOTS-1:0] fire,
    output logic [MAG_W-1:0]   ammo,
    output logic               reloading,
    output logic               dry_fire
);

    localparam int MAX_CYC = (COOLDOWN_CYC > RELOAD_CYC) ? COOLDOWN_CYC : RELOAD_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam int PW      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    localparam logic [TW-1:0]    COOL_LOAD   = TW'(COOLDOWN_CYC - 1);
    localparam logic [TW-1:0]    RELOAD_LOAD = TW'(RELOAD_CYC - 1);
    localparam logic [MAG_W-1:0] MAG_FULL    = MAG_W'(MAG_SIZE);

    typedef enum logic [1:0] {
        READY,
        COOLDOWN,
        RELOAD
    } state_t;

    state_t             state_q;
    logic               s1_q, s2_q, s3_q;
    logic [TW-1:0]      timer_q;
    logic [PW-1:0]      ptr_q;
    logic [MAG_W-1:0]   ammo_q;
    logic [N_SLOTS-1:0] fire_q;
    logic               dry_q;
    logic               reloading_q;

    logic               shotEdge;
    logic               grantValid_d;
    logic [PW-1:0]      grantIdx_d;
    logic [PW-1:0]      cand_d;
    logic [PW-1:0]      nextPtr_d;
    logic [N_SLOTS-1:0] grantOneHot_d;

    function automatic logic [PW-1:0] wrapAdd(input logic [PW-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= N_SLOTS) sum = sum - N_SLOTS;
        return PW'(sum);
    endfunction

    assign shotEdge = s2_q & ~s3_q;

    // First non-busy slot at or after the round-robin pointer, wrapping modulo N_SLOTS.
    always_comb begin
        grantValid_d = 1'b0;
        grantIdx_d   = '0;
        cand_d       = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            cand_d = wrapAdd(ptr_q, k);
            if (!grantValid_d && !slot_busy[cand_d]) begin
                grantValid_d = 1'b1;
                grantIdx_d   = cand_d;
            end
        end
        nextPtr_d     = wrapAdd(grantIdx_d, 1);
        grantOneHot_d = N_SLOTS'(1) << grantIdx_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= READY;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            timer_q     <= '0;
            ptr_q       <= '0;
            ammo_q      <= MAG_FULL;
            fire_q      <= '0;
            dry_q       <= 1'b0;
            reloading_q <= 1'b0;
        end else begin
            s1_q   <= shoot;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            fire_q <= '0;
            dry_q  <= 1'b0;
            case (state_q)
                READY: begin
                    if (shotEdge) begin
                        if (ammo_q == '0) begin
                            dry_q       <= 1'b1;
                            state_q     <= RELOAD;
                            timer_q     <= RELOAD_LOAD;
                            reloading_q <= 1'b1;
                        end else if (grantValid_d) begin
                            fire_q  <= grantOneHot_d;
                            ammo_q  <= ammo_q - MAG_W'(1);
                            ptr_q   <= nextPtr_d;
                            timer_q <= COOL_LOAD;
                            state_q <= COOLDOWN;
                        end else begin
                            dry_q <= 1'b1;
                        end
                    end else if (reload_req && (ammo_q < MAG_FULL)) begin
                        state_q     <= RELOAD;
                        timer_q     <= RELOAD_LOAD;
                        reloading_q <= 1'b1;
                    end
                end
                // An empty magazine at cooldown expiry rolls straight into a reload.
                COOLDOWN: begin
                    if (timer_q == '0) begin
                        if (ammo_q == '0) begin
                            state_q     <= RELOAD;
                            timer_q     <= RELOAD_LOAD;
                            reloading_q <= 1'b1;
                        end else begin
                            state_q <= READY;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                RELOAD: begin
                    if (timer_q == '0) begin
                        ammo_q      <= MAG_FULL;
                        state_q     <= READY;
                        reloading_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: state_q <= READY;
            endcase
        end
    end

    assign fire      = fire_q;
    assign dry_fire  = dry_q;
    assign ammo      = ammo_q;
    assign reloading = reloading_q;

endmodule
